// File: rtl/dcache_requester_if.sv
// rtl/dcache_requester_if.sv - CPU request/response and memory command signals of dcache_requester.
interface dcache_requester_if #(
    parameter int WORD_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [WORD_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [WORD_W-1:0] cpu_rdata;
    logic              d_readM;
    logic              d_writeM;
    logic [WORD_W-1:0] d_address;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, d_readM, d_writeM, d_address
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, d_readM, d_writeM, d_address
    );
endinterface

// File: rtl/dcache_requester.sv
// rtl/dcache_requester.sv - direct-mapped write-through data cache and memory initiator.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_requester #(
    parameter int WORD_W  = 16,
    parameter int IDX_W   = 3,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    dcache_requester_if.master bus,
    inout  wire  [WORD_W-1:0] d_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [WORD_W-1:0] hit_cnt,
    output logic [WORD_W-1:0] miss_cnt
`endif
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = WORD_W - IDX_W;
    localparam int CNT_W = $clog2(MEM_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];

    logic              rd_q, wr_q, ready_q;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;

    logic [IDX_W-1:0]  req_idx, mem_idx;
    logic [TAG_W-1:0]  req_tag, mem_tag;
    logic              lookup_hit;
    logic              rd_hit, start_rd, start_wr, rd_done, wr_done;

    assign req_idx    = bus.cpu_addr[IDX_W-1:0];
    assign req_tag    = bus.cpu_addr[WORD_W-1:IDX_W];
    assign mem_idx    = addr_q[IDX_W-1:0];
    assign mem_tag    = addr_q[WORD_W-1:IDX_W];
    assign lookup_hit = valid[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_n  = state;
        rd_hit   = 1'b0;
        start_rd = 1'b0;
        start_wr = 1'b0;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_we) begin
                        start_wr = 1'b1;
                        state_n  = WR_MEM;
                    end else if (lookup_hit) begin
                        rd_hit = 1'b1;
                    end else begin
                        start_rd = 1'b1;
                        state_n  = RD_MEM;
                    end
                end
            end
            // Read data is sampled one edge after the memory has seen MEM_LAT held edges.
            RD_MEM: begin
                if (cnt == RD_LAST) begin
                    rd_done = 1'b1;
                    state_n = RESP;
                end
            end
            WR_MEM: begin
                if (cnt == WR_LAST) begin
                    wr_done = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            valid   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ready_q <= rd_hit | rd_done | wr_done;
            // Address and command are latched once so they stay frozen for the whole access.
            if (start_rd || start_wr) begin
                cnt     <= '0;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                rd_q    <= start_rd;
                wr_q    <= start_wr;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (rd_hit) begin
                rdata_q <= data_q[req_idx];
            end
            if (rd_done) begin
                rd_q           <= 1'b0;
                rdata_q        <= d_data;
                valid[mem_idx] <= 1'b1;
            end
            if (wr_done) begin
                wr_q <= 1'b0;
            end
        end
    end

    // Line storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (rd_done) begin
            tag_q[mem_idx]  <= mem_tag;
            data_q[mem_idx] <= d_data;
        end else if (start_wr && lookup_hit) begin
            data_q[req_idx] <= bus.cpu_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (rd_hit || (start_wr && lookup_hit)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (start_rd || (start_wr && !lookup_hit)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

    assign bus.d_readM   = rd_q;
    assign bus.d_writeM  = wr_q;
    assign bus.d_address = addr_q;
    assign bus.cpu_ready = ready_q;
    assign bus.cpu_rdata = rdata_q;
    assign d_data        = wr_q ? wdata_q : {WORD_W{1'bz}};
endmodule

// File: tb/tb_dcache_requester.sv
// tb/tb_dcache_requester.sv - randomized self-checking bench for dcache_requester.
// Builds with or without DCACHE_STATS_EN.
module tb_dcache_requester;
    localparam int WORD_W  = 16;
    localparam int IDX_W   = 3;
    localparam int MEM_LAT = 2;
    localparam int LINES   = 1 << IDX_W;

    logic clk;
    logic reset_n;
    logic mem_load;
    wire  [WORD_W-1:0] d_data;

    dcache_requester_if #(.WORD_W(WORD_W)) bus ();

`ifdef DCACHE_STATS_EN
    wire [WORD_W-1:0] hit_cnt;
    wire [WORD_W-1:0] miss_cnt;
`endif

    dcache_requester #(.WORD_W(WORD_W), .IDX_W(IDX_W), .MEM_LAT(MEM_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .d_data  (d_data)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_val(input int a);
        if (a == 'h23) return 16'h6000;
        if (a == 'h2B) return 16'h4401;
        return 16'(a * 257) ^ 16'h5A5A;
    endfunction

    // Memory with MEM_LAT latency: read data appears only after the command is held MEM_LAT edges.
    logic [15:0] mem [256];
    int          mem_cnt;
    logic        mem_drive;
    logic [15:0] mem_q;

    assign mem_q     = mem[bus.d_address[7:0]];
    assign mem_drive = bus.d_readM && (mem_cnt >= MEM_LAT);
    assign d_data    = mem_drive ? mem_q : 16'bz;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
            mem_cnt <= 0;
        end else begin
            if (bus.d_readM || bus.d_writeM) mem_cnt <= mem_cnt + 1;
            else                             mem_cnt <= 0;
            if (bus.d_writeM && mem_cnt == MEM_LAT - 1) mem[bus.d_address[7:0]] <= d_data;
        end
    end

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which word each line holds, plus the memory contents as the CPU sees them.
    bit          m_valid [LINES];
    int          m_tag   [LINES];
    logic [15:0] ref_mem [256];
    int          m_hits;
    int          m_misses;

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic access(input bit we, input logic [15:0] addr, input logic [15:0] wd);
        int idx, edges, rdc, wrc, exp_edges, exp_rd, exp_wr;
        bit hit, got;
        idx = addr % LINES;
        hit = m_valid[idx] && (m_tag[idx] == addr / LINES);
        exp_edges = we ? MEM_LAT + 1 : (hit ? 1 : MEM_LAT + 2);
        exp_rd    = (!we && !hit) ? MEM_LAT + 1 : 0;
        exp_wr    = we ? MEM_LAT : 0;

        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        edges = 0; rdc = 0; wrc = 0; got = 0;
        while (!got && edges < 20) begin
            @(negedge clk);
            edges++;
            if (bus.d_readM || bus.d_writeM) begin
                check("cmd_excl", {31'd0, bus.d_readM & bus.d_writeM}, 0);
                check("cmd_addr", {16'd0, bus.d_address}, {16'd0, addr});
            end
            if (bus.d_readM) rdc++;
            if (bus.d_writeM) begin
                wrc++;
                check("wr_data", {16'd0, d_data}, {16'd0, wd});
            end
            if (bus.cpu_ready) got = 1;
        end
        bus.cpu_req = 1'b0;
        check("ready_seen", {31'd0, got}, 1);
        check(we ? "wr_latency" : (hit ? "hit_latency" : "miss_latency"), edges, exp_edges);
        check("rd_cmd_edges", rdc, exp_rd);
        check("wr_cmd_edges", wrc, exp_wr);
        if (!we) check("rdata", {16'd0, bus.cpu_rdata}, {16'd0, ref_mem[addr[7:0]]});

        if (hit) m_hits++;
        else     m_misses++;
        if (we) begin
            ref_mem[addr[7:0]] = wd;
        end else if (!hit) begin
            m_valid[idx] = 1;
            m_tag[idx]   = addr / LINES;
        end

        @(negedge clk);
        check("ready_pulse", {31'd0, bus.cpu_ready}, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        mem_load = 1'b1;
        reset_n  = 1'b0;
        #2;
        check("rst_readM",  {31'd0, bus.d_readM}, 0);
        check("rst_writeM", {31'd0, bus.d_writeM}, 0);
        check("rst_addr",   {16'd0, bus.d_address}, 0);
        check("rst_ready",  {31'd0, bus.cpu_ready}, 0);
        check("rst_rdata",  {16'd0, bus.cpu_rdata}, 0);
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        access(0, 16'h0023, 16'h0);
        access(0, 16'h0023, 16'h0);
        access(1, 16'h0023, 16'h1234);
        check("mem23", {16'd0, mem[8'h23]}, 32'h1234);
        access(0, 16'h0023, 16'h0);
        access(0, 16'h002B, 16'h0);
        access(0, 16'h0023, 16'h0);
        access(1, 16'h0005, 16'hBEEF);
        access(0, 16'h0005, 16'h0);

        // Abort a read miss to an aliasing address partway through.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0015;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_readM_before", {31'd0, bus.d_readM}, 1);
        reset_n = 1'b0;
        #1;
        check("mid_readM",  {31'd0, bus.d_readM}, 0);
        check("mid_ready",  {31'd0, bus.cpu_ready}, 0);
        check("mid_addr",   {16'd0, bus.d_address}, 0);
        bus.cpu_req = 1'b0;
        model_reset();
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt",  {16'd0, hit_cnt}, 0);
        check("rst_miss_cnt", {16'd0, miss_cnt}, 0);
`endif
        repeat (2) @(negedge clk);
        check("mid_ready_held", {31'd0, bus.cpu_ready}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        access(0, 16'h0005, 16'h0);
        access(0, 16'h0015, 16'h0);

        for (int n = 0; n < 300; n++) begin
            access(($urandom % 3) == 0, 16'($urandom % 32), 16'($urandom));
            repeat ($urandom % 3) @(negedge clk);
        end

`ifdef DCACHE_STATS_EN
        check("hit_cnt",  {16'd0, hit_cnt},  m_hits);
        check("miss_cnt", {16'd0, miss_cnt}, m_misses);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
